alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (BUS_WIDTH-wide; opcodes ADD=1, ADD_CARRY=2, SUB=3, INC=4, DEC=5, AND=6, NOT=7, ROL=8, ROR=9; others are invalid) between two requesters.
- Each requester presents an operation over a valid/ready handshake.
- A round-robin arbiter picks one operation per cycle and drives the ALU with it.
- The ALU result and flags are captured in a single-entry response register, tagged with the requester id, and handed downstream over a valid/ready handshake.

Parameters:
- BUS_WIDTH, 8, operand/result width; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_opcode  in  4  ALU opcode.
- req0_a, req0_b  in  BUS_WIDTH  operands.
- req0_carry_in  in  1  carry input for ADD_CARRY.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_carry_in: same as requester 0, for requester 1.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  downstream accepts the response.
- rsp_id  out  1  requester that issued the result.
- rsp_y  out  BUS_WIDTH  ALU result.
- rsp_carry_out, rsp_borrow, rsp_zero, rsp_parity, rsp_invalid_op  out  1 each  ALU flags, captured with rsp_y.

Behaviour:
- Reset (async assert, sync deassert by the system): rsp_valid=0, rsp_id=0, rsp_y=0, all rsp flags=0, last_grant=1 (so requester 0 wins the first contention). Any held response is discarded.
- can_accept = !rsp_valid | rsp_ready. The response slot is free, or drains this same cycle (full throughput, one op/cycle).
- Grant, combinational:
  - Only one valid requester: it wins.
  - Both valid: the requester != last_grant wins.
  - Neither valid: no grant.
- reqN_ready = grant==N & can_accept. At most one ready is high per cycle.
- Ready may depend on the other requester's valid. Requesters must not gate valid on ready.
- Transfer (fire) = reqN_valid & reqN_ready. On fire:
  - ALU inputs are muxed from the winner.
  - Next edge: rsp_* <= ALU outputs, rsp_id <= N, rsp_valid <= 1, last_grant <= N.
- Latency: exactly 1 cycle from fire to rsp_valid.
- No fire and rsp_ready & rsp_valid: rsp_valid <= 0 next edge. Data fields hold their last value.
- Backpressure: while rsp_valid & !rsp_ready:
  - all rsp_* fields are held stable;
  - both readys are 0;
  - last_grant does not change.
- A requester that is not granted must hold valid and its fields stable until it fires.
- When the ALU is not fired, its inputs are don't-care. The team drives them from requester 0 to avoid muxing glitches being relevant.
- Invalid opcode (0 or 10-15):
  - still accepted and arbitrated;
  - response carries y=0, carry_out=0, borrow=0, zero=1, parity=0, invalid_op=1.
- Arithmetic follows the ALU exactly:
  - ADD (1) discards carry.
  - ADD_CARRY (2) and INC (4) report carry_out.
  - SUB (3) and DEC (5) report borrow.
  - zero and parity are computed on y.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one with no bubble, and rsp_valid stays 1.
- Reset mid-operation: the pending response is lost and requesters must re-issue.
- Starvation bound: with both requesters continuously valid and rsp_ready=1, grants strictly alternate.

Decomposition:
- Package alu_pkg:
  - OP_ADD..OP_ROR opcode localparams (1..9);
  - the 4-bit opcode width constant;
  - shared by ALU, this block, and benches.
- Sub-module: one instance of the existing ALU module (BUS_WIDTH passed through).
- Arbiter, skid-free response register, and grant pointer are inline. No further sub-module is needed.

Test Plan:
- Single request: req0 ADD a=8'h0F b=8'h01, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, y=8'h10, zero=0, parity=1.
- Contention after reset: both valid (req0 INC a=8'hFF; req1 SUB a=8'h00 b=8'h01), rsp_ready=1:
  - cycle 1 grants req0 -> y=8'h00, carry_out=1, zero=1;
  - cycle 2 grants req1 -> y=8'hFF, borrow=1, parity=0;
  - grants then alternate 0,1,0,1.
- Backpressure: response held with rsp_ready=0 for 3 cycles -> rsp_* stable, req0_ready=req1_ready=0. On rsp_ready=1, the next queued op is accepted in the same cycle and rsp_valid stays 1.
- Invalid opcode: req1 opcode=4'hC -> rsp_invalid_op=1, y=0, zero=1, rsp_id=1.
- ADD_CARRY and rotate: req0 ADD_CARRY a=8'hFF b=8'h00 carry_in=1 -> y=8'h00, carry_out=1. Then ROL a=8'h81 -> y=8'h03, carry_out=0.
- Async reset asserted mid-cycle while rsp_valid=1 -> rsp_valid drops immediately without a clock edge. After release, the first contention grants req0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encodings and widths shared by the ALU, its users and
//               benches.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OPCODE_WIDTH = 4;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_ADD       = 4'd1;
    localparam opcode_t OP_ADD_CARRY = 4'd2;
    localparam opcode_t OP_SUB       = 4'd3;
    localparam opcode_t OP_INC       = 4'd4;
    localparam opcode_t OP_DEC       = 4'd5;
    localparam opcode_t OP_AND       = 4'd6;
    localparam opcode_t OP_NOT       = 4'd7;
    localparam opcode_t OP_ROL       = 4'd8;
    localparam opcode_t OP_ROR       = 4'd9;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational BUS_WIDTH-bit ALU with carry/borrow/zero/parity
//               and invalid-opcode flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic [BUS_WIDTH-1:0]    i_a,
    input  logic [BUS_WIDTH-1:0]    i_b,
    input  logic                    i_carry_in,
    output logic [BUS_WIDTH-1:0]    o_y,
    output logic                    o_carry_out,
    output logic                    o_borrow,
    output logic                    o_zero,
    output logic                    o_parity,
    output logic                    o_invalid_op
);

    logic [BUS_WIDTH:0] w_add;
    logic [BUS_WIDTH:0] w_add_carry;
    logic [BUS_WIDTH:0] w_inc;

    assign w_add       = {1'b0, i_a} + {1'b0, i_b};
    assign w_add_carry = w_add + {{BUS_WIDTH{1'b0}}, i_carry_in};
    assign w_inc       = {1'b0, i_a} + {{BUS_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        o_y          = '0;
        o_carry_out  = 1'b0;
        o_borrow     = 1'b0;
        o_invalid_op = 1'b0;
        case (i_opcode)
            OP_ADD:       o_y = w_add[BUS_WIDTH-1:0];
            OP_ADD_CARRY: {o_carry_out, o_y} = w_add_carry;
            OP_SUB: begin
                o_y      = i_a - i_b;
                o_borrow = (i_a < i_b);
            end
            OP_INC:       {o_carry_out, o_y} = w_inc;
            OP_DEC: begin
                o_y      = i_a - {{(BUS_WIDTH-1){1'b0}}, 1'b1};
                o_borrow = (i_a == '0);
            end
            OP_AND:       o_y = i_a & i_b;
            OP_NOT:       o_y = ~i_a;
            // Rotates never report the wrapped bit as a carry.
            OP_ROL:       o_y = {i_a[BUS_WIDTH-2:0], i_a[BUS_WIDTH-1]};
            OP_ROR:       o_y = {i_a[0], i_a[BUS_WIDTH-1:1]};
            default:      o_invalid_op = 1'b1;
        endcase
    end

    assign o_zero   = (o_y == '0);
    assign o_parity = ^o_y;

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one ALU between two requesters, with a
//               single-entry response register on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [OPCODE_WIDTH-1:0] req0_opcode,
    input  logic [BUS_WIDTH-1:0]    req0_a,
    input  logic [BUS_WIDTH-1:0]    req0_b,
    input  logic                    req0_carry_in,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [OPCODE_WIDTH-1:0] req1_opcode,
    input  logic [BUS_WIDTH-1:0]    req1_a,
    input  logic [BUS_WIDTH-1:0]    req1_b,
    input  logic                    req1_carry_in,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [BUS_WIDTH-1:0]    rsp_y,
    output logic                    rsp_carry_out,
    output logic                    rsp_borrow,
    output logic                    rsp_zero,
    output logic                    rsp_parity,
    output logic                    rsp_invalid_op
);

    logic                    r_rsp_valid;
    logic                    r_rsp_id;
    logic [BUS_WIDTH-1:0]    r_rsp_y;
    logic                    r_rsp_carry_out;
    logic                    r_rsp_borrow;
    logic                    r_rsp_zero;
    logic                    r_rsp_parity;
    logic                    r_rsp_invalid_op;
    logic                    r_last_grant;

    logic                    w_can_accept;
    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_fire0;
    logic                    w_fire1;
    logic                    w_fire;
    logic [OPCODE_WIDTH-1:0] w_alu_opcode;
    logic [BUS_WIDTH-1:0]    w_alu_a;
    logic [BUS_WIDTH-1:0]    w_alu_b;
    logic                    w_alu_carry_in;
    logic [BUS_WIDTH-1:0]    w_alu_y;
    logic                    w_alu_carry_out;
    logic                    w_alu_borrow;
    logic                    w_alu_zero;
    logic                    w_alu_parity;
    logic                    w_alu_invalid_op;

    assign w_can_accept = !r_rsp_valid || rsp_ready;

    // Under contention the requester that did not win last time goes first.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_grant0 && w_can_accept;
    assign req1_ready = w_grant1 && w_can_accept;

    assign w_fire0 = req0_valid && req0_ready;
    assign w_fire1 = req1_valid && req1_ready;
    assign w_fire  = w_fire0 || w_fire1;

    // Requester 0 drives the ALU whenever requester 1 is not firing.
    assign w_alu_opcode   = w_fire1 ? req1_opcode   : req0_opcode;
    assign w_alu_a        = w_fire1 ? req1_a        : req0_a;
    assign w_alu_b        = w_fire1 ? req1_b        : req0_b;
    assign w_alu_carry_in = w_fire1 ? req1_carry_in : req0_carry_in;

    alu #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_alu (
        .i_opcode     (w_alu_opcode),
        .i_a          (w_alu_a),
        .i_b          (w_alu_b),
        .i_carry_in   (w_alu_carry_in),
        .o_y          (w_alu_y),
        .o_carry_out  (w_alu_carry_out),
        .o_borrow     (w_alu_borrow),
        .o_zero       (w_alu_zero),
        .o_parity     (w_alu_parity),
        .o_invalid_op (w_alu_invalid_op)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid      <= 1'b0;
            r_rsp_id         <= 1'b0;
            r_rsp_y          <= '0;
            r_rsp_carry_out  <= 1'b0;
            r_rsp_borrow     <= 1'b0;
            r_rsp_zero       <= 1'b0;
            r_rsp_parity     <= 1'b0;
            r_rsp_invalid_op <= 1'b0;
            r_last_grant     <= 1'b1;
        end else if (w_fire) begin
            r_rsp_valid      <= 1'b1;
            r_rsp_id         <= w_fire1;
            r_rsp_y          <= w_alu_y;
            r_rsp_carry_out  <= w_alu_carry_out;
            r_rsp_borrow     <= w_alu_borrow;
            r_rsp_zero       <= w_alu_zero;
            r_rsp_parity     <= w_alu_parity;
            r_rsp_invalid_op <= w_alu_invalid_op;
            r_last_grant     <= w_fire1;
        end else if (rsp_ready) begin
            r_rsp_valid      <= 1'b0;
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_y          = r_rsp_y;
    assign rsp_carry_out  = r_rsp_carry_out;
    assign rsp_borrow     = r_rsp_borrow;
    assign rsp_zero       = r_rsp_zero;
    assign rsp_parity     = r_rsp_parity;
    assign rsp_invalid_op = r_rsp_invalid_op;

endmodule : alu_arbiter
`default_nettype wire
